// File: rtl/mdu_iterative.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_iterative: radix-2 RV32M multiply/divide unit with stall handshake.
// Optional MDU_FAST_MUL_EN: single-cycle multiplies. Revision 1.0
// ---------------------------------------------------------------------------
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_advance,
  input  logic            flush,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Start-cycle operand decode
  logic            is_div, a_signed, b_signed, a_neg, b_neg, start_neg;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic            div_by_zero, div_ovf;

  assign is_div   = funct3[2];
  assign a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign a_neg    = a_signed & rs1_data[XLEN-1];
  assign b_neg    = b_signed & rs2_data[XLEN-1];
  assign a_abs    = a_neg ? -rs1_data : rs1_data;
  assign b_abs    = b_neg ? -rs2_data : rs2_data;
  // Remainder follows the dividend sign; everything else uses the sign product.
  assign start_neg = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_by_zero = is_div & (rs2_data == '0);
  assign div_ovf     = is_div & ~funct3[0] &
                       (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
  assign special_res = div_by_zero ? (funct3[1] ? rs1_data : '1)
                                   : (funct3[1] ? '0 : rs1_data);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_a    = {{XLEN{a_neg}}, rs1_data};
  assign fast_b    = {{XLEN{b_neg}}, rs2_data};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  // One iteration: shift-add for multiply, restoring step for divide
  logic [XLEN:0]     mul_sum, div_rem, div_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opb_q};
  assign div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_rem - {1'b0, opb_q};

  always_comb begin
    acc_step = {mul_sum, acc_q[XLEN-1:1]};
    if (op_q[2]) begin
      if (div_diff[XLEN]) acc_step = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  assign prod_fix = neg_q ? -acc_step : acc_step;
  assign quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

  always_comb begin
    if (op_q[2])              fin_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == 3'b000)  fin_res = prod_fix[XLEN-1:0];
    else                      fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu_valid) begin
            op_d  = funct3;
            neg_d = start_neg;
            cnt_d = '0;
            if (is_div) begin
              opb_d = b_abs;
              acc_d = {{XLEN{1'b0}}, a_abs};
            end else begin
              opb_d = a_abs;
              acc_d = {{XLEN{1'b0}}, b_abs};
            end
            if (div_by_zero | div_ovf) begin
              result_d = special_res;
              state_d  = S_DONE;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!is_div) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end
`endif
            else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (ex_advance) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // No path from ex_advance/flush, so the hazard unit sees no loop.
  assign mdu_done   = (state_q == S_IDLE) ? ~mdu_valid : (state_q == S_DONE);
  assign mdu_result = result_q;

endmodule
`default_nettype wire
